// File: rtl/aes_gcm_ctr_decrypt.sv
// aes_gcm_ctr_decrypt: AES-GCM decrypt-path counter-mode stage.
// Turns ciphertext blocks into plaintext blocks with AES-128 under inc32 counters derived
// from J0. It also produces the tag mask EK(J0) for the downstream tag check.
// Optional build macro AES_GCM_DEC_TAIL_MASK_EN: when it is defined, the unused tail bits
// of a partial final block are zeroed. When it is not defined, the full XOR is output and
// the consumer truncates.
module aes_gcm_ctr_decrypt (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_new_instance,
  input  logic [0:127]  i_j0,
  input  logic [0:1407] i_key_schedule,
  input  logic [0:127]  i_instance_size,
  input  logic          i_ct_valid,
  input  logic [0:127]  i_ct,
  output logic          o_ct_ready,
  output logic          o_pt_valid,
  output logic [0:127]  o_pt,
  output logic          o_pt_last,
  input  logic          i_pt_ready,
  output logic [0:127]  o_ek_j0,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One AES round. The final round has no MixColumns. Byte k sits at bits [127-8k -: 8].
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] sh;
    logic [127:0] mc;
    logic [7:0]   a0, a1, a2, a3;
    sh = '0;
    mc = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sh[127-8*(4*c+r) -: 8] = sb(s[127-8*(4*((c+r)%4)+r) -: 8]);
    for (int c = 0; c < 4; c++) begin
      a0 = sh[127-32*c -: 8];
      a1 = sh[119-32*c -: 8];
      a2 = sh[111-32*c -: 8];
      a3 = sh[103-32*c -: 8];
      mc[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return (last ? sh : mc) ^ rk;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] blk, input logic [0:1407] ks);
    logic [127:0] s;
    s = blk ^ ks[0 +: 128];
    for (int r = 1; r <= 10; r++)
      s = aes_round(s, ks[128*r +: 128], r == 10);
    return s;
  endfunction

  function automatic logic [127:0] inc32(input logic [127:0] c);
    return {c[127:32], c[31:0] + 32'd1};
  endfunction

  state_t        state;
  logic [0:1407] ks_q;
  logic [127:0]  ctr;
  logic [38:0]   len_q;
  logic [32:0]   nblk;
  logic [32:0]   load_nblk;
  logic [127:0]  aes_out;
  logic [127:0]  pt_mask;
  logic          accept;
  logic          pt_hs;
  logic          unused_len;

  // len(A) and the len(C) bits above 2^39 play no part in this stage.
  assign unused_len = ^i_instance_size[0:88];

  // A single AES core serves both EK(J0) in LOAD and the data keystream in RUN.
  assign aes_out   = aes_enc(ctr, ks_q);
  assign load_nblk = {1'b0, len_q[38:7]} + {32'd0, |len_q[6:0]};
  assign o_ct_ready = (state == RUN) && (nblk != 33'd0) && (!o_pt_valid || i_pt_ready);
  assign accept    = i_ct_valid && o_ct_ready;
  assign pt_hs     = o_pt_valid && i_pt_ready;

  // Mask that clears the bits past len(C) on a partial final block.
  always_comb begin
    pt_mask = '1;
`ifdef AES_GCM_DEC_TAIL_MASK_EN
    if (nblk == 33'd1 && len_q[6:0] != 7'd0)
      pt_mask = ~({128{1'b1}} >> len_q[6:0]);
`else
    pt_mask = '1;
`endif
  end

  // Instance sequencing, counter stepping and the registered plaintext output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ks_q       <= '0;
      ctr        <= '0;
      len_q      <= '0;
      nblk       <= '0;
      o_pt_valid <= 1'b0;
      o_pt       <= '0;
      o_pt_last  <= 1'b0;
      o_ek_j0    <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_new_instance) begin
            ctr    <= i_j0;
            ks_q   <= i_key_schedule;
            len_q  <= i_instance_size[89:127];
            o_busy <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          o_ek_j0 <= aes_out;
          ctr     <= inc32(ctr);
          nblk    <= load_nblk;
          if (load_nblk == 33'd0) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            o_pt       <= (i_ct ^ aes_out) & pt_mask;
            o_pt_valid <= 1'b1;
            o_pt_last  <= (nblk == 33'd1);
            ctr        <= inc32(ctr);
            nblk       <= nblk - 33'd1;
          end else if (pt_hs) begin
            o_pt_valid <= 1'b0;
            o_pt_last  <= 1'b0;
          end
          if (pt_hs && o_pt_last) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_gcm_ctr_decrypt.sv
// tb_aes_gcm_ctr_decrypt: scoreboard bench for the GCM decrypt CTR stage.
// Expected plaintexts are the published GCM test-case vectors. Optional build macro
// AES_GCM_DEC_TAIL_MASK_EN selects the expected partial-tail block.
module tb_aes_gcm_ctr_decrypt;

  logic          clk;
  logic          rst;
  logic          i_new_instance;
  logic [0:127]  i_j0;
  logic [0:1407] i_key_schedule;
  logic [0:127]  i_instance_size;
  logic          i_ct_valid;
  logic [0:127]  i_ct;
  logic          o_ct_ready;
  logic          o_pt_valid;
  logic [0:127]  o_pt;
  logic          o_pt_last;
  logic          i_pt_ready;
  logic [0:127]  o_ek_j0;
  logic          o_busy;
  logic          o_done;

  aes_gcm_ctr_decrypt dut (
    .clk(clk), .rst(rst), .i_new_instance(i_new_instance), .i_j0(i_j0),
    .i_key_schedule(i_key_schedule), .i_instance_size(i_instance_size),
    .i_ct_valid(i_ct_valid), .i_ct(i_ct), .o_ct_ready(o_ct_ready),
    .o_pt_valid(o_pt_valid), .o_pt(o_pt), .o_pt_last(o_pt_last),
    .i_pt_ready(i_pt_ready), .o_ek_j0(o_ek_j0), .o_busy(o_busy), .o_done(o_done)
  );

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] ZERO_J0  = {96'd0, 32'd1};
  localparam logic [127:0] ZERO_EKJ0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] ZERO_H    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] C2_CT     = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] C3_KEY    = 128'hfeffe9928665731c6d6a8f9467308308;
  localparam logic [127:0] C3_J0     = 128'hcafebabefacedbaddecaf888_00000001;
  localparam logic [127:0] C3_CT [4] = '{
    128'h42831ec2217774244b7221b784d0d49c, 128'he3aa212f2c02a4e035c17e2329aca12e,
    128'h21d514b25466931c7d8f6a5aac84aa05, 128'h1ba30b396a0aac973d58e091473f5985};
  localparam logic [127:0] C3_PT [4] = '{
    128'hd9313225f88406e5a55909c5aff5269a, 128'h86a7a9531534f7da2e4c303d8a318a72,
    128'h1c3c0c95956809532fcf0e2449a6b525, 128'hb16aedf5aa0de657ba637b391aafd255};
  localparam logic [127:0] C4_TAIL_CT = 128'h1ba30b396a0aac973d58e091_00000000;
`ifdef AES_GCM_DEC_TAIL_MASK_EN
  localparam logic [127:0] C4_TAIL_PT = 128'hb16aedf5aa0de657ba637b39_00000000;
`else
  localparam logic [127:0] C4_TAIL_PT = 128'hb16aedf5aa0de657ba637b39_5d908bd0;
`endif

  typedef struct packed {
    logic [127:0] pt;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   hs_log[$];
  int   compared;
  int   mismatched;
  int   hs_count;
  int   cyc_count;
  int   base;

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[{x, 3'b000} +: 8];
  endfunction

  // AES-128 key expansion to produce the 11 round keys the DUT expects as input.
  function automatic logic [0:1407] keyExpand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [0:1407] ks;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rcon, 24'd0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ks[32*i +: 32] = w[i];
    return ks;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic startInstance(input logic [127:0] j0, input logic [127:0] key,
                               input logic [63:0] lenc);
    i_j0            = j0;
    i_key_schedule  = keyExpand(key);
    i_instance_size = {64'd0, lenc};
    i_new_instance  = 1'b1;
    @(posedge clk); #1;
    i_new_instance = 1'b0;
  endtask

  task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] pt, input logic last);
    int   n;
    exp_t e;
    n = 0;
    i_ct_valid = 1'b1;
    i_ct       = ct;
    @(negedge clk);
    while (!o_ct_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ct_accept", 128'(o_ct_ready), 128'd1);
    if (o_ct_ready) begin
      e.pt   = pt;
      e.last = last;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    i_ct_valid = 1'b0;
  endtask

  task automatic drainWait(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_drain"}, 128'(exp_q.size()), 128'd0);
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (!o_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done"}, 128'(o_done), 128'd1);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 128'(o_done), 128'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard on every plaintext handshake and polices stalls.
  task automatic runMonitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && o_pt_valid && i_pt_ready) begin
        hs_count++;
        hs_log.push_back(cyc_count);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pt", 128'(o_pt_valid), 128'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pt_data", o_pt, e.pt);
          checkOutput("pt_last", 128'(o_pt_last), 128'(e.last));
        end
      end else if (!rst && o_pt_valid && !i_pt_ready) begin
        checkOutput("stall_ct_ready", 128'(o_ct_ready), 128'd0);
        if (exp_q.size() != 0) begin
          checkOutput("stall_pt_hold", o_pt, exp_q[0].pt);
          checkOutput("stall_last_hold", 128'(o_pt_last), 128'(exp_q[0].last));
        end
      end
    end
  endtask

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure handshake spacing.
  always @(posedge clk) cyc_count <= cyc_count + 1;

  // Hard stop in case some wait is never satisfied.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    compared = 0; mismatched = 0; hs_count = 0; cyc_count = 0; base = 0;
    rst = 1'b1; i_new_instance = 1'b0; i_j0 = '0; i_key_schedule = '0;
    i_instance_size = '0; i_ct_valid = 1'b0; i_ct = '0; i_pt_ready = 1'b1;
    fork runMonitor(); join_none
    repeat (2) @(posedge clk); #1;
    checkOutput("rst_ct_ready", 128'(o_ct_ready), 128'd0);
    checkOutput("rst_pt_valid", 128'(o_pt_valid), 128'd0);
    checkOutput("rst_pt_last", 128'(o_pt_last), 128'd0);
    checkOutput("rst_busy", 128'(o_busy), 128'd0);
    checkOutput("rst_done", 128'(o_done), 128'd0);
    checkOutput("rst_pt", o_pt, 128'd0);
    checkOutput("rst_ek_j0", o_ek_j0, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] zero-length C");
    startInstance(ZERO_J0, 128'd0, 64'd0);
    @(negedge clk);
    checkOutput("zl_load_busy", 128'(o_busy), 128'd1);
    checkOutput("zl_load_ct_ready", 128'(o_ct_ready), 128'd0);
    checkOutput("zl_load_done", 128'(o_done), 128'd0);
    @(negedge clk);
    checkOutput("zl_done", 128'(o_done), 128'd1);
    checkOutput("zl_done_busy", 128'(o_busy), 128'd0);
    checkOutput("zl_done_ct_ready", 128'(o_ct_ready), 128'd0);
    checkOutput("zl_ek_j0", o_ek_j0, ZERO_EKJ0);
    @(negedge clk);
    checkOutput("zl_done_pulse", 128'(o_done), 128'd0);
    @(posedge clk); #1;

    $display("[TB] single block");
    startInstance(ZERO_J0, 128'd0, 64'd128);
    applyStimulus(C2_CT, 128'd0, 1'b1);
    drainWait("single");
    waitDone("single");
    checkOutput("single_ek_j0", o_ek_j0, ZERO_EKJ0);

    $display("[TB] full blocks with stray start");
    base = hs_count;
    startInstance(C3_J0, C3_KEY, 64'd512);
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(C3_CT[i], C3_PT[i], i == 3);
      end
      begin
        @(posedge clk); #1;
        i_new_instance = 1'b1; i_j0 = '0; i_instance_size = '0;
        @(posedge clk); #1;
        i_new_instance = 1'b0;
      end
    join
    drainWait("full");
    checkOutput("full_count", 128'(hs_count - base), 128'd4);
    if (hs_log.size() >= base + 4)
      checkOutput("full_throughput", 128'(hs_log[base+3] - hs_log[base]), 128'd3);
    waitDone("full");

    $display("[TB] backpressure");
    base = hs_count;
    startInstance(C3_J0, C3_KEY, 64'd512);
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(C3_CT[i], C3_PT[i], i == 3);
      end
      begin
        int n;
        n = 0;
        while (hs_count < base + 1 && n < 100) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk); #1;
        i_pt_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        i_pt_ready = 1'b1;
      end
    join
    drainWait("bp");
    checkOutput("bp_count", 128'(hs_count - base), 128'd4);
    waitDone("bp");

    $display("[TB] partial tail");
    startInstance(C3_J0, C3_KEY, 64'd480);
    for (int i = 0; i < 3; i++) applyStimulus(C3_CT[i], C3_PT[i], 1'b0);
    applyStimulus(C4_TAIL_CT, C4_TAIL_PT, 1'b1);
    drainWait("tail");
    waitDone("tail");

    $display("[TB] counter wrap");
    startInstance({96'd0, 32'hFFFFFFFF}, 128'd0, 64'd256);
    applyStimulus(128'd0, ZERO_H, 1'b0);
    applyStimulus(128'd0, ZERO_EKJ0, 1'b1);
    drainWait("wrap");
    waitDone("wrap");

    $display("[TB] reset mid-instance");
    startInstance(C3_J0, C3_KEY, 64'd512);
    applyStimulus(C3_CT[0], C3_PT[0], 1'b0);
    applyStimulus(C3_CT[1], C3_PT[1], 1'b0);
    i_pt_ready = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_pt_valid", 128'(o_pt_valid), 128'd0);
    checkOutput("mid_rst_pt", o_pt, 128'd0);
    checkOutput("mid_rst_pt_last", 128'(o_pt_last), 128'd0);
    checkOutput("mid_rst_ct_ready", 128'(o_ct_ready), 128'd0);
    checkOutput("mid_rst_busy", 128'(o_busy), 128'd0);
    checkOutput("mid_rst_done", 128'(o_done), 128'd0);
    checkOutput("mid_rst_ek_j0", o_ek_j0, 128'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    i_pt_ready = 1'b1;
    @(posedge clk); #1;
    startInstance(ZERO_J0, 128'd0, 64'd128);
    applyStimulus(C2_CT, 128'd0, 1'b1);
    drainWait("post_rst");
    waitDone("post_rst");
    checkOutput("post_rst_ek_j0", o_ek_j0, ZERO_EKJ0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/aes_gcm_ctr_decrypt.md
# aes_gcm_ctr_decrypt

AES-GCM receive-side counter-mode stage. It takes the pre-counter block J0 and the expanded key schedule produced by the H/J0 pipeline stage, then streams ciphertext blocks in and plaintext blocks out under valid/ready handshakes. It also generates the tag mask EK(J0) for the downstream tag comparator, and sits between the H/J0 stage and the GHASH/tag-verify stage on the decrypt path.

## Interface
- No parameters.
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- i_new_instance  input  1  start pulse; J0, key schedule and size sampled with it
- i_j0  input  [0:127]  pre-counter block {IV, 32'd1}
- i_key_schedule  input  [0:1407]  AES-128 round keys 0..10
- i_instance_size  input  [0:127]  bits 0:63 len(A), bits 64:127 len(C), both in bits
- i_ct_valid  input  1  ciphertext block valid
- i_ct  input  [0:127]  ciphertext block
- o_ct_ready  output  1  block accepted when valid & ready
- o_pt_valid  output  1  plaintext block valid
- o_pt  output  [0:127]  plaintext block
- o_pt_last  output  1  marks final plaintext block
- i_pt_ready  input  1  downstream accepts plaintext
- o_ek_j0  output  [0:127]  AES_K(J0) tag mask, held until next instance
- o_busy  output  1  instance in progress
- o_done  output  1  one-cycle pulse at end of instance

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- **IDLE:**
  - i_new_instance=1 captures J0, key schedule and len(C), then goes to LOAD.
  - i_new_instance is ignored in every other state.
- **LOAD (1 cycle):**
  - o_ek_j0 <= AES_K(J0).
  - ctr <= inc32(J0).
  - nblk <= ceil(len(C)/128), computed from len(C)[25:63]; upper len bits are ignored.
  - nblk==0 goes to DONE; otherwise goes to RUN.
- **inc32:** low 32 bits of the counter increment mod 2^32; upper 96 bits are unchanged.
- **RUN:**
  - o_ct_ready = (nblk!=0) & (!o_pt_valid | i_pt_ready).
  - On accept:
    - o_pt <= i_ct ^ AES_K(ctr).
    - o_pt_valid <= 1.
    - o_pt_last <= (nblk==1).
    - ctr <= inc32(ctr).
    - nblk <= nblk-1.
  - On plaintext handshake with no new accept, o_pt_valid <= 0.
  - Handshake of the block with o_pt_last=1 goes to DONE.
- **DONE (1 cycle):** o_done=1, then IDLE.
- AES_K uses the shared combinational AES-128 encrypt function over the 1408-bit schedule.
- len(A) is carried but not used.

## Timing
- **Reset values (async):** state IDLE; o_ct_ready, o_pt_valid, o_pt_last, o_busy, o_done = 0; o_pt, o_ek_j0, ctr, nblk = 0.
- **Start sequence:** start sampled at edge N; LOAD is cycle N+1; earliest o_ct_ready=1 is cycle N+2.
- **Latency:** ciphertext accepted at edge M gives o_pt_valid=1 from cycle M+1.
- **Throughput:** 1 block/cycle while i_pt_ready=1.
- **Backpressure:**
  - o_pt, o_pt_valid and o_pt_last hold stable while o_pt_valid=1 and i_pt_ready=0.
  - o_ct_ready is 0 during that time.
- **Simultaneous events:** plaintext handshake and new ciphertext accept in the same cycle reloads o_pt; o_pt_valid stays 1.
- **o_busy** is 1 in LOAD and RUN.
- **o_ek_j0** is valid from cycle N+2 until the next LOAD.
- **Zero-length C:** LOAD, then DONE; o_done is at cycle N+2.
- **Reset mid-instance:** everything returns to reset values immediately; a partially output block is discarded.

## Configuration
- **AES_GCM_DEC_TAIL_MASK_EN:**
  - Defined: on the final block, when r = len(C) mod 128 is nonzero, o_pt bits r..127 are forced to 0.
  - Undefined: the final block is output as the full 128-bit XOR, and the consumer truncates.

## Test plan
- **Zero-length C:** key=0, J0=0^96||00000001, len(C)=0 -> no o_ct_ready; o_ek_j0=58e2fccefa7e3061367f1d57a4e7455a; o_done one cycle.
- **Single block:** key=0, J0 as above, len(C)=128, ct=0388dace60b6a392f328c2b971b2fe78 -> o_pt=0, o_pt_last=1, then o_done.
- **Full blocks:** NIST GCM case 3 (key feffe9928665731c6d6a8f9467308308, IV cafebabefacedbaddecaf888, len(C)=512) -> first pt d9313225f88406e5a55909c5aff5269a; all 4 blocks match the standard vector, back-to-back at 1/cycle.
- **Partial tail:** case 4 (len(C)=480), macro defined -> last block bits 96..127 = 0; macro undefined -> last block equals the full 128-bit XOR of ct with AES_K(ctr).
- **Backpressure and counter wrap:**
  - Hold i_pt_ready=0 for 5 cycles mid-stream -> o_pt stable, o_ct_ready=0, no block lost or duplicated.
  - J0 low word FFFFFFFF -> first data counter low word 00000000, upper 96 bits unchanged.
- **Reset and start hygiene:**
  - rst asserted after block 2 of 4 -> all outputs 0 immediately; a fresh instance after reset decrypts correctly.
  - i_new_instance during RUN is ignored.
